// File: rtl/ransac_reader_pkg.sv
// rtl/ransac_reader_pkg.sv - state enum, 4 KB boundary constant and burst sizing helpers
package ransac_reader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   localparam int unsigned BOUNDARY_4K = 4096;

   // AXI size code for a beat of data_width bits
   function automatic logic [2:0] arsize_of(input int unsigned data_width);
      return 3'($clog2(data_width / 8));
   endfunction

   // beats in the next burst: limited by what is left, the burst cap and the 4 KB page end
   function automatic logic [8:0] burst_len(
      input logic [31:0]  remaining,
      input logic [11:0]  addr_low,
      input int unsigned  max_beats,
      input int unsigned  size_log2
   );
      logic [31:0] to_boundary;
      logic [31:0] len;
      to_boundary = (BOUNDARY_4K - {20'd0, addr_low}) >> size_log2;
      len = remaining;
      if (len > max_beats) len = max_beats;
      if (len > to_boundary) len = to_boundary;
      return len[8:0];
   endfunction

endpackage

// File: rtl/ransac_sync_fifo.sv
// rtl/ransac_sync_fifo.sv - first-word-fall-through synchronous FIFO, output zeroed when empty
module ransac_sync_fifo #(
   parameter int unsigned width = 8,
   parameter int unsigned depth = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic [width-1:0] push_data,
   input  logic             pop,
   output logic             valid,
   output logic [width-1:0] pop_data
);

   localparam int unsigned PW = (depth > 1) ? $clog2(depth) : 1;
   localparam int unsigned CW = $clog2(depth + 1);

   logic [width-1:0] mem [depth];
   logic [PW-1:0]    wr_q;
   logic [PW-1:0]    rd_q;
   logic [CW-1:0]    count_q;
   logic             do_push;
   logic             do_pop;

   assign valid    = (count_q != '0);
   assign do_push  = push && (count_q != CW'(depth));
   assign do_pop   = pop && valid;
   assign pop_data = valid ? mem[rd_q] : '0;

   // storage write, no reset needed since reads are gated by valid
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_q] <= push_data;
   end

   // pointers and occupancy
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         if (do_push) wr_q <= (wr_q == PW'(depth - 1)) ? '0 : wr_q + PW'(1);
         if (do_pop)  rd_q <= (rd_q == PW'(depth - 1)) ? '0 : rd_q + PW'(1);
         case ({do_push, do_pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: ;
         endcase
      end
   end

endmodule

// File: rtl/ransac_burst_reader.sv
// rtl/ransac_burst_reader.sv - AXI burst reader, optional counters under RANSAC_BURST_READER_STATS_EN
module ransac_burst_reader
   import ransac_reader_pkg::*;
#(
   parameter int unsigned memory_addr_width = 32,
   parameter int unsigned memory_data_width = 32,
   parameter int unsigned max_burst_beats   = 16,
   parameter int unsigned max_outstanding   = 4,
   parameter int unsigned count_width       = 21
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [memory_addr_width-1:0] cmd_addr,
   input  logic [count_width-1:0]       cmd_count,
   input  logic                         cmd_valid,
   output logic                         cmd_ready,
   output logic [memory_data_width-1:0] data_out,
   output logic                         data_last,
   output logic                         data_error,
   output logic                         data_valid,
   input  logic                         data_ready,
   output logic [memory_addr_width-1:0] memory_araddr,
   output logic [7:0]                   memory_arlen,
   output logic [2:0]                   memory_arsize,
   output logic                         memory_arvalid,
   input  logic                         memory_arready,
   input  logic [memory_data_width-1:0] memory_rdata,
   input  logic [1:0]                   memory_rresp,
   input  logic                         memory_rlast,
   input  logic                         memory_rvalid,
   output logic                         memory_rready
`ifdef RANSAC_BURST_READER_STATS_EN
   ,
   output logic [31:0]                  stat_bursts,
   output logic [31:0]                  stat_beats
`endif
);

   localparam int unsigned BYTES      = memory_data_width / 8;
   localparam int unsigned SIZE_LOG2  = $clog2(BYTES);
   localparam int unsigned FIFO_DEPTH = max_outstanding * max_burst_beats;
   localparam int unsigned CW         = $clog2(FIFO_DEPTH + 1);
   localparam int unsigned OW         = $clog2(max_outstanding + 1);
   localparam logic [memory_addr_width-1:0] ALIGN_MASK = ~memory_addr_width'(BYTES - 1);
   localparam logic [2:0] ARSIZE = arsize_of(memory_data_width);

   state_t                       state_q, state_d;
   logic                         alive_q;
   logic [memory_addr_width-1:0] addr_q;
   logic [count_width-1:0]       remaining_q;
   logic [count_width-1:0]       left_q;
   logic [OW-1:0]                outstanding_q;
   logic [CW-1:0]                committed_q;
   logic [8:0]                   burst_l;
   logic                         ar_ok, final_ar;
   logic                         cmd_hs, ar_hs, r_hs, r_last_hs, pop;
   logic [memory_data_width:0]   fifo_dout;
   logic                         unused_rresp;

   assign unused_rresp = memory_rresp[0];

   assign burst_l   = burst_len(32'(remaining_q), addr_q[11:0], max_burst_beats, SIZE_LOG2);
   // committed_q counts beats held in the FIFO plus beats requested but not yet arrived
   assign ar_ok     = (remaining_q != '0) && (outstanding_q < OW'(max_outstanding))
                      && ((32'(FIFO_DEPTH) - 32'(committed_q)) >= 32'(burst_l));
   assign cmd_hs    = cmd_valid && cmd_ready;
   assign ar_hs     = memory_arvalid && memory_arready;
   assign r_hs      = memory_rvalid && memory_rready;
   assign r_last_hs = r_hs && memory_rlast;
   assign pop       = data_valid && data_ready;
   assign final_ar  = ar_hs && (remaining_q == count_width'(burst_l));

   // AR payload only changes on a handshake, so it is stable while waiting for arready
   assign memory_araddr = memory_arvalid ? addr_q : '0;
   assign memory_arlen  = memory_arvalid ? 8'(burst_l - 9'd1) : '0;
   assign memory_arsize = memory_arvalid ? ARSIZE : '0;

   assign data_out   = fifo_dout[memory_data_width-1:0];
   assign data_error = fifo_dout[memory_data_width];
   assign data_last  = data_valid && (left_q == count_width'(1));

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= ST_IDLE;
      else        state_q <= state_d;
   end

   // next-state decode
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (cmd_hs && (cmd_count != '0)) state_d = ST_ISSUE;
         ST_ISSUE: if (final_ar) state_d = ST_DRAIN;
         ST_DRAIN: if (pop && data_last) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   // handshake outputs per state
   always_comb begin
      cmd_ready      = 1'b0;
      memory_arvalid = 1'b0;
      memory_rready  = 1'b0;
      case (state_q)
         ST_IDLE:  cmd_ready = alive_q;
         ST_ISSUE: begin
            memory_arvalid = ar_ok;
            memory_rready  = 1'b1;
         end
         ST_DRAIN: memory_rready = 1'b1;
         default:  ;
      endcase
   end

   // command tracking: aligned address, beats left to request, beats left to deliver
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alive_q     <= 1'b0;
         addr_q      <= '0;
         remaining_q <= '0;
         left_q      <= '0;
      end else begin
         alive_q <= 1'b1;
         if (cmd_hs) begin
            addr_q      <= cmd_addr & ALIGN_MASK;
            remaining_q <= cmd_count;
            left_q      <= cmd_count;
         end else begin
            if (ar_hs) begin
               addr_q      <= addr_q + (memory_addr_width'(burst_l) << SIZE_LOG2);
               remaining_q <= remaining_q - count_width'(burst_l);
            end
            if (pop) left_q <= left_q - count_width'(1);
         end
      end
   end

   // outstanding bursts and FIFO credit accounting
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         outstanding_q <= '0;
         committed_q   <= '0;
      end else begin
         case ({ar_hs, r_last_hs})
            2'b10:   outstanding_q <= outstanding_q + OW'(1);
            2'b01:   if (outstanding_q != '0) outstanding_q <= outstanding_q - OW'(1);
            default: ;
         endcase
         committed_q <= committed_q + (ar_hs ? CW'(burst_l) : '0) - (pop ? CW'(1) : '0);
      end
   end

   ransac_sync_fifo #(
      .width (memory_data_width + 1),
      .depth (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (r_hs),
      .push_data ({memory_rresp[1], memory_rdata}),
      .pop       (pop),
      .valid     (data_valid),
      .pop_data  (fifo_dout)
   );

`ifdef RANSAC_BURST_READER_STATS_EN
   // free-running event counters, cleared only by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat_bursts <= '0;
         stat_beats  <= '0;
      end else begin
         if (ar_hs) stat_bursts <= stat_bursts + 32'd1;
         if (pop)   stat_beats  <= stat_beats + 32'd1;
      end
   end
`endif

endmodule

// File: doc/ransac_burst_reader.md
RANSAC_BURST_READER -- requirements
Module: ransac_burst_reader

Interface
REQ-001 SHALL have parameter memory_addr_width, default 32, AXI read address width.
REQ-002 SHALL have parameter memory_data_width, default 32, beat width; legal values 8..1024, powers of two.
REQ-003 SHALL have parameter max_burst_beats, default 16, maximum beats per AR burst; legal values 1..256.
REQ-004 SHALL have parameter max_outstanding, default 4, maximum issued-but-unfinished bursts.
REQ-005 SHALL have parameter count_width, default 21, width of the command beat count.
REQ-006 SHALL use one clock; reset is asynchronous and active-low.
REQ-007 clock  in  1  sole clock, rising edge.
REQ-008 reset  in  1  asynchronous, active-low reset.
REQ-009 cmd_addr  in  memory_addr_width  start byte address.
REQ-010 cmd_count  in  count_width  beats to read.
REQ-011 cmd_valid / cmd_ready  in / out  1 each  command handshake.
REQ-012 data_out  out  memory_data_width  read beat.
REQ-013 data_last / data_error  out  1 each  final beat of command / beat had RRESP[1] set.
REQ-014 data_valid / data_ready  out / in  1 each  output stream handshake.
REQ-015 memory_araddr, memory_arlen[7:0], memory_arsize[2:0], memory_arvalid  out  AXI AR channel.
REQ-016 memory_arready  in  1  AR accept.
REQ-017 memory_rdata, memory_rresp[1:0], memory_rlast, memory_rvalid  in  AXI R channel.
REQ-018 memory_rready  out  1  R accept.

Function
REQ-019 SHALL implement states IDLE, ISSUE, DRAIN. cmd_ready SHALL be high only in IDLE.
REQ-020 Accept with cmd_count>0: IDLE->ISSUE. Accept with cmd_count==0: remain IDLE, issue no AR, emit no beat.
REQ-021 ISSUE->DRAIN when the AR carrying the final beat handshakes. DRAIN->IDLE on the data_valid&data_ready cycle with data_last=1.
REQ-022 Low log2(memory_data_width/8) bits of cmd_addr SHALL be forced to zero.
REQ-023 Burst length L SHALL be min(remaining beats, max_burst_beats, beats to next 4 KB boundary). memory_arlen = L-1. Address SHALL advance by L*bytes after each AR handshake.
REQ-024 memory_arsize SHALL equal log2(memory_data_width/8), constant. Burst type is INCR (integrator ties ARBURST=01).
REQ-025 memory_arvalid SHALL first assert the cycle after command accept. It SHALL deassert when outstanding bursts == max_outstanding. It SHALL deassert when FIFO free space minus reserved beats < L. All AR outputs SHALL hold stable while arvalid & !arready.
REQ-026 Internal FIFO depth SHALL be max_outstanding*max_burst_beats. Credits SHALL guarantee no overflow. memory_rready SHALL be high in ISSUE/DRAIN and low in IDLE.
REQ-027 Outstanding burst count SHALL decrement on an R handshake with rlast=1. Simultaneous AR and final-R handshakes leave the count unchanged.
REQ-028 data_valid SHALL assert no earlier than one cycle after the R handshake. data_out/data_last/data_error SHALL hold while data_valid & !data_ready. Throughput SHALL be one beat/cycle.
REQ-029 An error response SHALL NOT abort the command. All cmd_count beats SHALL still be delivered.

Reset
REQ-030 Asserting reset SHALL, asynchronously and at any time, force IDLE, clear the FIFO, counters and credits, and drive cmd_ready=0. All other outputs SHALL be 0.
REQ-031 cmd_ready SHALL rise the first cycle after reset deassertion. Beats from bursts in flight across reset are not recovered.

Configuration
REQ-032 With RANSAC_BURST_READER_STATS_EN defined, SHALL add 32-bit outputs stat_bursts (AR handshakes) and stat_beats (output handshakes). Both wrap at 2^32 and clear only on reset.
REQ-033 Without the macro, those ports and counters SHALL be absent; all other behaviour identical.

Structure
REQ-034 Package ransac_reader_pkg SHALL hold the state enum, the 4 KB boundary constant, and the arsize/burst-length helper functions.
REQ-035 The FIFO SHALL be the sub-module ransac_sync_fifo (parametrised width/depth, first-word-fall-through).

Verification
REQ-036 addr 0x1000, count 40, burst 16, arready=1: AR lens 15,15,7 at 0x1000/0x1040/0x1080; 40 beats out; last on beat 40.
REQ-037 addr 0x0FF8, count 4, 32-bit: bursts L=2 at 0x0FF8, then L=2 at 0x1000 (4 KB split).
REQ-038 count 200, memory never returns R: exactly max_outstanding (4) ARs issued, then arvalid low.
REQ-039 data_ready low 100 cycles, count 64: no FIFO overflow; no data lost; order preserved.
REQ-040 RRESP=10 on beat 3 of 8: data_error=1 only on beat 3; 8 beats delivered. Also count 0: no AR; cmd_ready high next cycle.
REQ-041 Reset asserted mid-DRAIN: outputs 0 immediately; cmd_ready=1 one cycle after release.
